// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline register chain with central per-stage normal/stall/bubble control
module pipe_stage_chain #(
  parameter int STAGES   = 5,
  parameter int W        = 64,
  parameter int COLLAPSE = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  input  logic [STAGES-1:0]   stall_req,
  input  logic [STAGES-1:0]   flush_req,
  input  logic [STAGES*W-1:0] xform,
  output logic [STAGES-1:0]   stage_valid,
  output logic [STAGES*W-1:0] stage_data,
  output logic [2*STAGES-1:0] stage_stat,
  output logic                retire_valid,
  output logic [W-1:0]        retire_data,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);
  localparam logic [1:0] NORMAL = 2'd0, STALL = 2'd1, BUBBLE = 2'd2;
  logic [STAGES-1:0] valid, hold, kill, valid_n;
  logic [STAGES-1:0][W-1:0] data, data_n, xf;
  logic [STAGES-1:0][1:0] stat;
  logic unused_xf;
  assign xf = xform;
  assign unused_xf = ^xf[STAGES-1];
  assign stage_valid = valid;
  assign stage_data = data;
  assign stage_stat = stat;
  assign retire_valid = valid[STAGES-1] & ~stall_req[STAGES-1] & ~reset;
  assign retire_data = data[STAGES-1];
  assign in_ready = ~reset & ~hold[0] & ~(|flush_req);
  // hold ripples from the oldest stage down; kill covers everything younger than the oldest flusher
  always_comb begin
    hold = '0;
    kill = '0;
    hold[STAGES-1] = valid[STAGES-1] & stall_req[STAGES-1];
    for (int k = STAGES-2; k >= 0; k--) begin
      hold[k] = (stall_req[k] | hold[k+1]) & (valid[k] | (COLLAPSE == 0));
      kill[k] = kill[k+1] | flush_req[k+1];
    end
  end
  always_comb begin
    valid_n = '0;
    data_n = '0;
    stat = {STAGES{BUBBLE}};
    if (in_valid & in_ready) begin
      valid_n[0] = 1'b1;
      data_n[0] = in_data;
      stat[0] = NORMAL;
    end else if (~kill[0] & hold[0]) begin
      valid_n[0] = valid[0];
      data_n[0] = data[0];
      stat[0] = STALL;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (~kill[k] & hold[k]) begin
        valid_n[k] = valid[k];
        data_n[k] = data[k];
        stat[k] = STALL;
      end else if (valid[k-1] & ~hold[k-1] & ~kill[k-1]) begin
        valid_n[k] = 1'b1;
        data_n[k] = xf[k-1];
        stat[k] = NORMAL;
      end
    end
    if (reset) stat = {STAGES{BUBBLE}};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      data <= '0;
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      valid <= valid_n;
      data <= data_n;
      retire_cnt <= retire_cnt + CNT_W'(retire_valid);
      bubble_cnt <= bubble_cnt + CNT_W'(!retire_valid);
    end
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: randomized and directed checks of two chains (collapsing and lockstep) against a reference model
module tb_pipe_stage_chain;
  localparam int S = 5, W = 32;
  localparam logic [1:0] NORMAL = 2'd0, STALL = 2'd1, BUBBLE = 2'd2;
  logic clk = 0, reset = 1, in_valid = 0, salt = 0;
  logic [W-1:0] in_data = '0;
  logic [S-1:0] stall = '0, flush = '0;
  logic [S*W-1:0] xf0, xf1, sd0, sd1;
  logic [S-1:0] sv0, sv1;
  logic [2*S-1:0] st0, st1;
  logic rdy0, rdy1, rv0, rv1;
  logic [W-1:0] rd0, rd1;
  logic [31:0] rc0, bc0;
  logic [3:0] rc1, bc1;
  int n_checks = 0, n_fail = 0;
  logic mv [2][S];
  logic [W-1:0] md [2][S];
  logic nv [2][S];
  logic [W-1:0] nd [2][S];
  longint unsigned mret [2], mbub [2], nret [2], nbub [2];
  logic [W-1:0] rq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < S; g++) begin : g_xf
    assign xf0[g*W +: W] = sd0[g*W +: W] + 32'd1 + (salt ? 32'(g << 8) : 32'd0);
    assign xf1[g*W +: W] = sd1[g*W +: W] + 32'd1 + (salt ? 32'(g << 8) : 32'd0);
  end

  pipe_stage_chain #(.STAGES(S), .W(W), .COLLAPSE(1), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .stall_req(stall), .flush_req(flush), .xform(xf0), .stage_valid(sv0), .stage_data(sd0),
    .stage_stat(st0), .retire_valid(rv0), .retire_data(rd0), .retire_cnt(rc0), .bubble_cnt(bc0));

  pipe_stage_chain #(.STAGES(S), .W(W), .COLLAPSE(0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .stall_req(stall), .flush_req(flush), .xform(xf1), .stage_valid(sv1), .stage_data(sd1),
    .stage_stat(st1), .retire_valid(rv1), .retire_data(rd1), .retire_cnt(rc1), .bubble_cnt(bc1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // collapsing: held iff a contiguous run of valid stages from k reaches a stalled stage
  function automatic logic mhold(input int i, input int k);
    if (i == 0) begin
      for (int j = k; j < S; j++) begin
        if (!mv[i][j]) return 1'b0;
        if (stall[j]) return 1'b1;
      end
      return 1'b0;
    end
    if (mv[i][S-1] && stall[S-1]) return 1'b1;
    for (int j = k; j < S-1; j++) if (stall[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic eval(input int i);
    logic [S*W-1:0] sd;
    logic [S-1:0] sv;
    logic [2*S-1:0] st;
    logic rdy, rv, ready, ret;
    logic [W-1:0] rd;
    logic [63:0] rc, bc, mask;
    logic h [S];
    logic [1:0] es;
    int fo;
    sd = i ? sd1 : sd0;
    sv = i ? sv1 : sv0;
    st = i ? st1 : st0;
    rdy = i ? rdy1 : rdy0;
    rv = i ? rv1 : rv0;
    rd = i ? rd1 : rd0;
    rc = i ? 64'(rc1) : 64'(rc0);
    bc = i ? 64'(bc1) : 64'(bc0);
    mask = i ? 64'hf : 64'hffff_ffff;
    fo = -1;
    for (int j = 0; j < S; j++) if (flush[j]) fo = j;
    for (int k = 0; k < S; k++) h[k] = mhold(i, k);
    ready = !reset && !h[0] && flush == '0;
    ret = !reset && mv[i][S-1] && !stall[S-1];
    check($sformatf("c%0d.in_ready", i), 64'(rdy), 64'(ready));
    check($sformatf("c%0d.retire_valid", i), 64'(rv), 64'(ret));
    check($sformatf("c%0d.retire_data", i), 64'(rd), 64'(md[i][S-1]));
    check($sformatf("c%0d.retire_cnt", i), rc, mret[i] & mask);
    check($sformatf("c%0d.bubble_cnt", i), bc, mbub[i] & mask);
    for (int k = 0; k < S; k++) begin
      check($sformatf("c%0d.stage_valid[%0d]", i, k), 64'(sv[k]), 64'(mv[i][k]));
      check($sformatf("c%0d.stage_data[%0d]", i, k), 64'(sd[k*W +: W]), 64'(md[i][k]));
      es = BUBBLE;
      nv[i][k] = 1'b0;
      nd[i][k] = '0;
      if (k < fo) es = BUBBLE;
      else if (k == 0 && in_valid && ready) begin
        es = NORMAL; nv[i][k] = 1'b1; nd[i][k] = in_data;
      end else if (h[k]) begin
        es = STALL; nv[i][k] = mv[i][k]; nd[i][k] = md[i][k];
      end else if (k > 0 && mv[i][k-1] && !h[k-1] && k-1 >= fo) begin
        es = NORMAL; nv[i][k] = 1'b1;
        nd[i][k] = md[i][k-1] + 32'd1 + (salt ? 32'((k-1) << 8) : 32'd0);
      end
      if (reset) begin
        es = BUBBLE; nv[i][k] = 1'b0; nd[i][k] = '0;
      end
      check($sformatf("c%0d.stage_stat[%0d]", i, k), 64'(st[2*k +: 2]), 64'(es));
    end
    nret[i] = reset ? 0 : mret[i] + (ret ? 1 : 0);
    nbub[i] = reset ? 0 : mbub[i] + (ret ? 0 : 1);
  endtask

  task automatic step();
    @(negedge clk);
    eval(0);
    eval(1);
    if (rv0) rq.push_back(rd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < S; k++) begin
        mv[i][k] = nv[i][k];
        md[i][k] = nd[i][k];
      end
      mret[i] = nret[i];
      mbub[i] = nbub[i];
    end
  endtask

  task automatic feed(input int n, input logic [W-1:0] base, input logic inc);
    for (int j = 0; j < n; j++) begin
      in_valid = 1;
      in_data = inc ? base + 32'(j) : base;
      step();
    end
    in_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < S; k++) begin
        mv[i][k] = 0;
        md[i][k] = '0;
      end
      mret[i] = 0;
      mbub[i] = 0;
    end
    @(posedge clk);
    #1;
    step();
    reset = 0;
    rq.delete();
    feed(8, 32'd1, 1);
    repeat (8) step();
    check("stream_count", 64'(rq.size()), 64'd8);
    for (int n = 0; n < 8 && n < rq.size(); n++) check("stream_data", 64'(rq[n]), 64'(n + 5));
    check("stream_retire_cnt", 64'(rc0), 64'd8);
    feed(6, 32'd20, 1);
    in_valid = 1;
    stall = 5'b00100;
    repeat (3) step();
    stall = '0;
    feed(4, 32'd40, 1);
    repeat (8) step();
    for (int j = 0; j < 4; j++) begin
      in_valid = (j != 1);
      in_data = 32'(100 + j);
      step();
    end
    in_valid = 0;
    check("collapse_setup", 64'(sv0), 64'b01011);
    stall = 5'b01000;
    step();
    check("collapse_c1", 64'(sv0), 64'b01110);
    check("collapse_c0", 64'(sv1), 64'b01011);
    stall = '0;
    repeat (8) step();
    feed(5, 32'd10, 0);
    flush = 5'b01000;
    step();
    flush = '0;
    check("flush_valid", 64'(sv0), 64'b10000);
    check("flush_data", 64'(sd0[4*W +: W]), 64'd14);
    repeat (6) step();
    feed(6, 32'd60, 1);
    in_valid = 1;
    flush = 5'b10000;
    stall = 5'b00010;
    step();
    flush = '0;
    stall = '0;
    in_valid = 0;
    check("flush_beats_stall", 64'(sv0), 64'b00000);
    repeat (3) step();
    feed(6, 32'd80, 1);
    reset = 1;
    step();
    reset = 0;
    check("reset_valid", 64'(sv0), 64'd0);
    check("reset_retire_cnt", 64'(rc0), 64'd0);
    check("reset_bubble_cnt", 64'(bc0), 64'd0);
    rq.delete();
    feed(3, 32'd1, 1);
    repeat (8) step();
    check("restream_count", 64'(rq.size()), 64'd3);
    for (int n = 0; n < 3 && n < rq.size(); n++) check("restream_data", 64'(rq[n]), 64'(n + 5));
    salt = 1;
    repeat (3000) begin
      reset = ($urandom_range(99) == 0);
      in_valid = ($urandom_range(3) != 0);
      in_data = $urandom;
      for (int k = 0; k < S; k++) begin
        stall[k] = ($urandom_range(9) == 0);
        flush[k] = ($urandom_range(39) == 0);
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
